// File: rtl/vga_pkg.sv
// vga_pkg: text-mode geometry, control codes and the built-in glyph table.
// The table covers 'A'..'C' in full and draws every other printable code as a box.
package vga_pkg;
   localparam int TEXT_COLS = 16;
   localparam int TEXT_ROWS = 16;
   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam int CELLS = TEXT_COLS * TEXT_ROWS;
   localparam int LINE_W = $clog2(CHAR_H);
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_FF = 8'h0C;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [63:0] GLYPH_A = 64'h183C_6666_7E66_6666;
   localparam logic [63:0] GLYPH_B = 64'h7C66_667C_6666_667C;
   localparam logic [63:0] GLYPH_C = 64'h3C66_6060_6060_663C;
   localparam logic [63:0] GLYPH_BOX = 64'h7E42_4242_4242_427E;

   // Glyph bodies occupy lines 2..9 of the 16-line cell; all other lines are blank.
   function automatic logic [CHAR_W-1:0] font_row(input logic [6:0] code, input logic [LINE_W-1:0] line);
      logic [63:0] g;
      logic [2:0] k;
      g = (code == 7'h41) ? GLYPH_A :
          (code == 7'h42) ? GLYPH_B :
          (code == 7'h43) ? GLYPH_C :
          (code > 7'h20 && code < 7'h7F) ? GLYPH_BOX : 64'd0;
      k = 3'(line - 4'd2);
      return (line >= 4'd2 && line <= 4'd9) ? g[CHAR_W*(7-k) +: CHAR_W] : '0;
   endfunction
endpackage

// File: rtl/text_char_buffer_font_rom.sv
// font_rom: 2048 x 8 glyph ROM addressed by {code[6:0], line[3:0]}, one-cycle registered output.
module font_rom
   import vga_pkg::*;
(
   input  logic              clk40MHz,
   input  logic              rst,
   input  logic [10:0]       addr,
   output logic [CHAR_W-1:0] pixel
);
   always_ff @(posedge clk40MHz)
      pixel <= rst ? '0 : font_row(addr[10:4], addr[3:0]);
endmodule

// File: rtl/text_char_buffer.sv
// text_char_buffer: 16x16 character store with a cursor-driven write port and a
// two-stage display read path (character RAM, then font ROM) feeding char_pixel.
module text_char_buffer
   import vga_pkg::*;
#(
   parameter logic [7:0] FILL_CHAR = ASCII_SPACE
) (
   input  logic              clk40MHz,
   input  logic              rst,
   input  logic [7:0]        char_xy,
   input  logic [LINE_W-1:0] char_line,
   output logic [CHAR_W-1:0] char_pixel,
   input  logic              wr_valid,
   input  logic [7:0]        wr_char,
   output logic              wr_ready,
   output logic [7:0]        cursor_xy,
   output logic              busy
);
   typedef enum logic {CLEAR, RUN} state_t;

   state_t state, state_n;
   logic [7:0] clr_cnt, clr_n, cursor_n, waddr, wdata;
   logic we;
   logic [6:0] code_q;
   logic [LINE_W-1:0] line_q;
   logic [7:0] ram [CELLS];

   assign wr_ready = state == RUN;
   assign busy = state == CLEAR;

   // Cursor arithmetic on the packed {row, col} byte gives the row carry and the
   // full-screen wrap in both directions for free.
   always_comb begin
      state_n = state;
      clr_n = clr_cnt;
      cursor_n = cursor_xy;
      we = 1'b0;
      waddr = cursor_xy;
      wdata = wr_char;
      if (state == CLEAR) begin
         we = 1'b1;
         waddr = clr_cnt;
         wdata = FILL_CHAR;
         clr_n = clr_cnt + 8'd1;
         state_n = (clr_cnt == 8'hFF) ? RUN : CLEAR;
      end else if (wr_valid) begin
         if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
            we = 1'b1;
            cursor_n = cursor_xy + 8'd1;
         end else if (wr_char == ASCII_LF) begin
            cursor_n = {cursor_xy[7:4] + 4'd1, 4'd0};
         end else if (wr_char == ASCII_BS) begin
            we = 1'b1;
            waddr = cursor_xy - 8'd1;
            wdata = ASCII_SPACE;
            cursor_n = cursor_xy - 8'd1;
         end else if (wr_char == ASCII_FF) begin
            cursor_n = '0;
            clr_n = '0;
            state_n = CLEAR;
         end
      end
   end

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         state <= CLEAR;
         clr_cnt <= '0;
         cursor_xy <= '0;
         code_q <= '0;
         line_q <= '0;
      end else begin
         state <= state_n;
         clr_cnt <= clr_n;
         cursor_xy <= cursor_n;
         code_q <= ram[char_xy][6:0];
         line_q <= char_line;
      end
   end

   // Read-first RAM: the display port samples the old contents on a colliding write.
   always_ff @(posedge clk40MHz)
      if (we && !rst) ram[waddr] <= wdata;

   font_rom u_font_rom (
      .clk40MHz(clk40MHz),
      .rst     (rst),
      .addr    ({code_q, line_q}),
      .pixel   (char_pixel)
   );
endmodule

// File: doc/text_char_buffer.md
# text_char_buffer

Character store and font lookup for the on-screen text box. It holds a 16×16 grid of ASCII codes written one character at a time by a cursor-driven write port (keyboard/UART side). On the display side it answers character-cell/line requests from the text-box renderer with the 8-pixel font row, at fixed latency. It sits directly upstream of the rectangle-text renderer and drives its `char_pixel` input.

## Interface
Parameters:
- `FILL_CHAR`, default 8'h20: code written to every cell during a clear.

Ports:
- `clk40MHz`  in  1  pixel clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `char_xy`  in  8  cell address from the renderer; [3:0] = column, [7:4] = row
- `char_line`  in  4  glyph row, 0..15, within the cell
- `char_pixel`  out  8  font row bits; bit 7 = leftmost pixel
- `wr_valid`  in  1  `wr_char` holds a character to process
- `wr_char`  in  8  ASCII code
- `wr_ready`  out  1  the block can accept a character this cycle
- `cursor_xy`  out  8  current cursor cell, same encoding as `char_xy`
- `busy`  out  1  a clear is in progress

## Operation
- Storage: 256 × 8 character RAM. One write port is owned by the FSM. One read port serves the display.
- A transfer is accepted on a rising edge with `wr_valid && wr_ready`. `wr_char` is sampled only on that edge.
- FSM states:
  - CLEAR: writes `FILL_CHAR` to address `clr_cnt`, with `clr_cnt` counting 0→255, one cell per cycle. After address 255 it goes to RUN. `wr_ready`=0 and `busy`=1 throughout.
  - RUN: `wr_ready`=1 and `busy`=0. Each accepted character is handled in that same cycle as follows:
    - 0x20..0x7E: write the code at the cursor, then advance the cursor.
    - 0x0A (newline): column←0, row←row+1 mod 16. Nothing is written.
    - 0x08 (backspace): move the cursor back one cell, then write 0x20 at the new cell.
    - 0x0C (form feed): cursor←0, `clr_cnt`←0, go to CLEAR.
    - Any other code: accepted and ignored.
- Cursor advance: column+1. After column 15, the column goes to 0 and the row goes to row+1. After cell (15,15) the cursor wraps to (0,0). There is no scrolling; old text is overwritten.
- Backspace from (0,0) wraps to (15,15). Backspace from column 0 of row r goes to (15, r−1).
- Display path:
  - Stage 1: registered RAM read at `char_xy`; `char_line` is delayed one cycle alongside it.
  - Stage 2: registered font ROM read at {code[6:0], line_d}.
  - Codes ≥0x80 use only their low 7 bits.
  - The read port is independent of FSM state, so the display keeps reading during CLEAR.
- Read and write to the same address in the same cycle: the read returns the old contents (read-first).
- Reset behaviour:
  - Forces CLEAR with `clr_cnt`=0 and cursor=0.
  - Resets the pipeline registers, so `char_pixel`=0 during and after reset until new data arrives.
  - Asserting `rst` in the middle of a clear or a write restarts the full clear. The partial write is discarded.

## Timing
- Reset values:
  - `char_pixel`=0, `cursor_xy`=0, `wr_ready`=0, `busy`=1.
  - The first RUN cycle is 256 cycles after `rst` deasserts. `wr_ready` rises on that edge.
- Read latency is exactly 2 cycles: `char_pixel` at edge t+2 reflects `char_xy`/`char_line` sampled at edge t. There is one result per cycle with no bubbles.
- Write side:
  - The RAM write and the cursor update take effect on the accepting edge. `cursor_xy` shows the new value the next cycle.
  - Throughput is one character per cycle in RUN.
  - A form feed accepted at edge t drops `wr_ready` from t+1 for 256 cycles.
- A character written at edge t is visible on the display path to a read sampled at edge t+1 or later.

## Structure
- Constants go in `vga_pkg`: `TEXT_COLS`=16, `TEXT_ROWS`=16, `CHAR_W`=8, `CHAR_H`=16, `ASCII_LF`, `ASCII_BS`, `ASCII_FF`, `ASCII_SPACE`.
- The FSM state enum (CLEAR, RUN) is local to the module.
- One sub-module: `font_rom`. It is a 2048 × 8 synchronous ROM, address {code[6:0], line[3:0]}, initialised from a font file, with a 1-cycle registered output.
- The character RAM is inferred inside `text_char_buffer`.

## Test plan
- Reset, then hold `wr_valid`=0:
  - `wr_ready`=0 for exactly 256 cycles.
  - Every cell reads 0x20 afterwards.
  - `char_pixel` matches the space glyph, all 8'h00.
- Write "A" (0x41) after reset:
  - `cursor_xy`=0x01.
  - Reading `char_xy`=0x00, `char_line`=5 gives the ROM row for {0x41,5} two cycles later.
- Write 16 × 0x42 then 0x43:
  - 0x43 lands at cell 0x10.
  - `cursor_xy`=0x11.
- Newline and backspace from (0,0): send 0x0A at cursor (0,0), then 0x08 twice:
  - Cursor goes 0x10 → 0x0F → 0x0E.
  - Cells 0x0F and 0x0E hold 0x20.
- Send 256 printable chars, then 0x0C mid-stream:
  - Cursor wraps to 0x00 after the 256th char.
  - The form feed causes a 256-cycle `busy` period, then all cells read 0x20.
- Assert `rst` at `clr_cnt`=100 during a clear:
  - The clear restarts from 0.
  - `wr_ready` stays low for 256 cycles after `rst` deasserts.
